alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
Parametrised, handshaked successor to the single-cycle execute ALU. It is used in each execute lane of the superscalar core.
- Accepts one one-hot-decoded operation per cycle and returns a registered result with NZCV flags and a passthrough tag.
- MUL is executed iteratively and stalls the lane.
- Valid/ready on both sides lets the issue and writeback stages apply backpressure independently.

Parameters:
WIDTH, 16, operand/result width in bits (>=4, power of two)
IMM_WIDTH, 5, immediate field width; sign-extended to WIDTH
TAG_WIDTH, 4, opaque destination/ROB tag carried input->output
SHW, $clog2(WIDTH), shift-amount bits taken from operand 2 (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operation presented
in_ready  out  1  block can accept this cycle
alusignals  in  12  one-hot op: b0 add, b1 ld, b2 st, b3 sub, b4 mul, b5 cmp, b6 mov, b7 or, b8 and, b9 not, b10 lsl, b11 lsr
op1  in  WIDTH  operand 1
op2  in  WIDTH  operand 2
immx  in  IMM_WIDTH  immediate
isimmediate  in  1  1: B = sext(immx), else B = op2
in_tag  in  TAG_WIDTH  tag
out_valid  out  1  result held
out_ready  in  1  consumer accepts
aluresult  out  WIDTH  result
flags  out  4  {N,Z,C,V}
err  out  1  illegal alusignals (zero or multi-hot)
out_tag  out  TAG_WIDTH  tag of result

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE; out_valid=0; aluresult=0; flags=0; err=0; out_tag=0; the multiplier accumulator is cleared.
- Reset mid-MUL aborts the operation; no result is produced.
- Transfer rules: input accepted when in_valid&&in_ready; output consumed when out_valid&&out_ready.
- Output register: aluresult, flags, err and out_tag are stable while out_valid=1 and out_ready=0.
- in_ready = (state==IDLE) && (!out_valid || out_ready); same-cycle consume+accept is allowed, giving full throughput.
- States:
  - IDLE: a non-MUL op accepted at edge N loads the output register; out_valid=1 after edge N (latency 1). An accepted MUL goes to MUL.
  - MUL: radix-2 shift-add, one bit per cycle, WIDTH iterations. After the last iteration go to DONE.
  - DONE: load the output and return to IDLE once the output register is free (!out_valid || out_ready).
  - MUL result is therefore visible WIDTH+1 cycles after acceptance when unstalled.
- Operations, with B the selected operand 2:
  - add/ld/st: op1+B.
  - sub: op1-B.
  - cmp: computes op1-B and updates flags; aluresult=0.
  - mul: low WIDTH bits of op1*B.
  - mov: B.
  - or/and: bitwise.
  - not: ~B.
  - lsl/lsr: op1 shifted logically by B[SHW-1:0], zero fill.
- Flags:
  - N = result MSB; Z = (result==0). For cmp, N and Z come from the difference.
  - add/ld/st: C = carry out, V = signed overflow.
  - sub/cmp: C = no-borrow (op1>=B unsigned), V = signed overflow.
  - All other ops: C=V=0.
- Illegal alusignals: aluresult=0, flags=0, err=1, latency 1; err=0 for legal ops.
- in_valid=0 while in_ready=1: nothing changes except out_valid clearing on consume.
- Inputs are sampled only at acceptance; changes to op1/op2/immx during MUL have no effect.

Test Plan:
- Reset, then add op1=0005 op2=0003 isimmediate=0, out_ready=1 -> next cycle aluresult=0008, flags=0000, out_tag=in_tag.
- sub 0003-0005 -> FFFE, N=1 Z=0 C=0 V=0. Then cmp 0005,0005 -> aluresult=0000, Z=1 C=1.
- mul 0005*0003 -> in_ready=0 for 17 cycles; aluresult=000F valid 17 cycles after acceptance. Assert rst_n=0 during a second MUL -> out_valid stays 0, state returns to IDLE.
- add isimmediate=1 immx=11111 op1=0005 -> 0004, C=1 V=0. lsl 0005 by 3 -> 0028. lsr 8000 by 17 (shift = 1) -> 4000.
- Hold out_ready=0 with back-to-back adds -> out_valid stays 1 with the first result stable and in_ready=0. Raise out_ready -> one result per cycle with no loss or duplication.
- alusignals=000 and =011 -> err=1, aluresult=0000.

Source files
------------

// File: rtl/alu_pipe.sv
// Handshaked execute ALU: one-hot op in, registered result + NZCV + tag out; latency 1, MUL WIDTH+1.
// in_ready drops while a MUL iterates or while an unconsumed result sits in the output register.
module alu_pipe #(
   parameter int WIDTH     = 16,
   parameter int IMM_WIDTH = 5,
   parameter int TAG_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [11:0]          alusignals,
   input  logic [WIDTH-1:0]     op1,
   input  logic [WIDTH-1:0]     op2,
   input  logic [IMM_WIDTH-1:0] immx,
   input  logic                 isimmediate,
   input  logic [TAG_WIDTH-1:0] in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     aluresult,
   output logic [3:0]           flags,
   output logic                 err,
   output logic [TAG_WIDTH-1:0] out_tag
);
   localparam int SHW = $clog2(WIDTH);

   localparam logic [11:0] OP_ADD = 12'h001, OP_LD  = 12'h002, OP_ST  = 12'h004,
                           OP_SUB = 12'h008, OP_MUL = 12'h010, OP_CMP = 12'h020,
                           OP_MOV = 12'h040, OP_OR  = 12'h080, OP_AND = 12'h100,
                           OP_NOT = 12'h200, OP_LSL = 12'h400, OP_LSR = 12'h800;

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
   state_t state, state_nxt;

   logic [WIDTH-1:0]     b_sel;
   logic [WIDTH:0]       sum, diff;
   logic [WIDTH-1:0]     res_c, nz_src;
   logic                 c_c, v_c, err_c;
   logic [3:0]           flags_c;
   logic                 accept, out_free, is_mul;

   logic [WIDTH-1:0]     mcand, mplier, acc;
   logic [SHW-1:0]       cnt;
   logic [TAG_WIDTH-1:0] mtag;

   assign b_sel    = isimmediate ? WIDTH'($signed(immx)) : op2;
   assign out_free = !out_valid || out_ready;
   assign in_ready = (state == IDLE) && out_free;
   assign accept   = in_valid && in_ready;
   assign is_mul   = (alusignals == OP_MUL);

   always_comb begin
      sum   = {1'b0, op1} + {1'b0, b_sel};
      diff  = {1'b0, op1} - {1'b0, b_sel};
      res_c = '0;
      c_c   = 1'b0;
      v_c   = 1'b0;
      err_c = 1'b0;
      case (alusignals)
         OP_ADD, OP_LD, OP_ST: begin
            res_c = sum[WIDTH-1:0];
            c_c   = sum[WIDTH];
            v_c   = (op1[WIDTH-1] == b_sel[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
         end
         OP_SUB, OP_CMP: begin
            res_c = (alusignals == OP_CMP) ? '0 : diff[WIDTH-1:0];
            c_c   = ~diff[WIDTH];
            v_c   = (op1[WIDTH-1] != b_sel[WIDTH-1]) && (diff[WIDTH-1] != op1[WIDTH-1]);
         end
         OP_MUL: res_c = '0;
         OP_MOV: res_c = b_sel;
         OP_OR:  res_c = op1 | b_sel;
         OP_AND: res_c = op1 & b_sel;
         OP_NOT: res_c = ~b_sel;
         OP_LSL: res_c = op1 << b_sel[SHW-1:0];
         OP_LSR: res_c = op1 >> b_sel[SHW-1:0];
         default: err_c = 1'b1;
      endcase
      // cmp discards the difference but still reports its N/Z
      nz_src  = (alusignals == OP_CMP) ? diff[WIDTH-1:0] : res_c;
      flags_c = err_c ? 4'b0000 : {nz_src[WIDTH-1], (nz_src == '0), c_c, v_c};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && is_mul) state_nxt = MUL;
         MUL:     if (cnt == SHW'(WIDTH-1)) state_nxt = DONE;
         DONE:    if (out_free) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Radix-2 shift-add; only the low WIDTH product bits are kept
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         mtag   <= '0;
      end else if (accept && is_mul) begin
         mcand  <= op1;
         mplier <= b_sel;
         acc    <= '0;
         cnt    <= '0;
         mtag   <= in_tag;
      end else if (state == MUL) begin
         if (mplier[0]) acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + SHW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         aluresult <= '0;
         flags     <= 4'b0000;
         err       <= 1'b0;
         out_tag   <= '0;
      end else if (state == DONE && out_free) begin
         out_valid <= 1'b1;
         aluresult <= acc;
         flags     <= {acc[WIDTH-1], (acc == '0), 2'b00};
         err       <= 1'b0;
         out_tag   <= mtag;
      end else if (accept && !is_mul) begin
         out_valid <= 1'b1;
         aluresult <= res_c;
         flags     <= flags_c;
         err       <= err_c;
         out_tag   <= in_tag;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vector table, MUL/reset/backpressure sequences, random scoreboard run.
module tb_alu_pipe;
   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, isimmediate, out_valid, out_ready, err;
   logic [11:0] alusignals;
   logic [15:0] op1, op2, aluresult;
   logic [4:0]  immx;
   logic [3:0]  in_tag, out_tag, flags;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(16), .IMM_WIDTH(5), .TAG_WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alusignals(alusignals), .op1(op1), .op2(op2), .immx(immx),
      .isimmediate(isimmediate), .in_tag(in_tag), .out_valid(out_valid),
      .out_ready(out_ready), .aluresult(aluresult), .flags(flags), .err(err),
      .out_tag(out_tag)
   );

   typedef struct {
      logic [11:0] sig;
      logic [15:0] a;
      logic [15:0] b;
      logic [4:0]  imm;
      logic        isimm;
      logic [15:0] res;
      logic [3:0]  fl;
      logic        er;
   } vec_t;

   typedef struct {
      logic [15:0] res;
      logic [3:0]  fl;
      logic        er;
      logic [3:0]  tag;
   } exp_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   function automatic longint to_signed16(input longint u);
      return (u >= 32768) ? u - 65536 : u;
   endfunction

   // Reference model: the operation rules evaluated with plain integer arithmetic
   function automatic exp_t model(input logic [11:0] sig, input logic [15:0] a,
                                  input logic [15:0] b2, input logic [4:0] imm,
                                  input logic isimm);
      exp_t   e;
      longint ua, ub, si, sr, r;
      logic   c, v;
      e  = '{res: 16'h0, fl: 4'h0, er: 1'b0, tag: 4'h0};
      si = longint'(imm);
      if (si >= 16) si = si - 32;
      ua = longint'(a);
      if (isimm) ub = si & 64'hFFFF;
      else       ub = longint'(b2);
      r = 0; c = 1'b0; v = 1'b0;
      case (sig)
         12'h001, 12'h002, 12'h004: begin
            r  = ua + ub;
            c  = (r > 65535);
            sr = to_signed16(ua) + to_signed16(ub);
            v  = (sr > 32767) || (sr < -32768);
         end
         12'h008, 12'h020: begin
            r  = ua - ub;
            c  = (ua >= ub);
            sr = to_signed16(ua) - to_signed16(ub);
            v  = (sr > 32767) || (sr < -32768);
         end
         12'h010: r = ua * ub;
         12'h040: r = ub;
         12'h080: r = ua | ub;
         12'h100: r = ua & ub;
         12'h200: r = ~ub;
         12'h400: r = ua << (ub % 16);
         12'h800: r = ua >> (ub % 16);
         default: e.er = 1'b1;
      endcase
      r = r & 64'hFFFF;
      if (!e.er) begin
         e.fl  = {(r >= 32768), (r == 0), c, v};
         e.res = (sig == 12'h020) ? 16'h0000 : 16'(r);
      end
      return e;
   endfunction

   task automatic run_op(input vec_t vv, input logic [3:0] tag, input int idx);
      int lat, lows;
      @(negedge clk);
      alusignals = vv.sig; op1 = vv.a; op2 = vv.b; immx = vv.imm;
      isimmediate = vv.isimm; in_tag = tag; in_valid = 1'b1;
      #1 chk($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      op1 = 16'($urandom); op2 = 16'($urandom); immx = 5'($urandom);
      lat = 0; lows = 0;
      while (!out_valid && lat < 40) begin
         if (!in_ready) lows++;
         @(negedge clk);
         lat++;
      end
      chk($sformatf("v%0d_latency", idx), 32'(lat), (vv.sig == 12'h010) ? 32'd17 : 32'd0);
      chk($sformatf("v%0d_stall", idx), 32'(lows), (vv.sig == 12'h010) ? 32'd17 : 32'd0);
      chk($sformatf("v%0d_result", idx), 32'(aluresult), 32'(vv.res));
      chk($sformatf("v%0d_flags", idx), 32'(flags), 32'(vv.fl));
      chk($sformatf("v%0d_err", idx), 32'(err), 32'(vv.er));
      chk($sformatf("v%0d_tag", idx), 32'(out_tag), 32'(tag));
   endtask

   vec_t tbl[23];
   exp_t sb[$];

   initial begin
      int   bad, n;
      exp_t e, got;
      tbl[0]  = '{12'h001, 16'h0005, 16'h0003, 5'h00, 1'b0, 16'h0008, 4'b0000, 1'b0};
      tbl[1]  = '{12'h008, 16'h0003, 16'h0005, 5'h00, 1'b0, 16'hFFFE, 4'b1000, 1'b0};
      tbl[2]  = '{12'h020, 16'h0005, 16'h0005, 5'h00, 1'b0, 16'h0000, 4'b0110, 1'b0};
      tbl[3]  = '{12'h010, 16'h0005, 16'h0003, 5'h00, 1'b0, 16'h000F, 4'b0000, 1'b0};
      tbl[4]  = '{12'h001, 16'h0005, 16'h1234, 5'h1F, 1'b1, 16'h0004, 4'b0010, 1'b0};
      tbl[5]  = '{12'h400, 16'h0005, 16'h0003, 5'h00, 1'b0, 16'h0028, 4'b0000, 1'b0};
      tbl[6]  = '{12'h800, 16'h8000, 16'h0011, 5'h00, 1'b0, 16'h4000, 4'b0000, 1'b0};
      tbl[7]  = '{12'h000, 16'h1234, 16'h5678, 5'h00, 1'b0, 16'h0000, 4'b0000, 1'b1};
      tbl[8]  = '{12'h003, 16'h1234, 16'h5678, 5'h00, 1'b0, 16'h0000, 4'b0000, 1'b1};
      tbl[9]  = '{12'h001, 16'h7FFF, 16'h0001, 5'h00, 1'b0, 16'h8000, 4'b1001, 1'b0};
      tbl[10] = '{12'h008, 16'h8000, 16'h0001, 5'h00, 1'b0, 16'h7FFF, 4'b0011, 1'b0};
      tbl[11] = '{12'h040, 16'h1111, 16'h2222, 5'h10, 1'b1, 16'hFFF0, 4'b1000, 1'b0};
      tbl[12] = '{12'h200, 16'h1111, 16'h0000, 5'h00, 1'b0, 16'hFFFF, 4'b1000, 1'b0};
      tbl[13] = '{12'h100, 16'hF0F0, 16'h0FF0, 5'h00, 1'b0, 16'h00F0, 4'b0000, 1'b0};
      tbl[14] = '{12'h080, 16'h0000, 16'h0000, 5'h00, 1'b0, 16'h0000, 4'b0100, 1'b0};
      tbl[15] = '{12'h002, 16'hFFFF, 16'h0001, 5'h00, 1'b0, 16'h0000, 4'b0110, 1'b0};
      tbl[16] = '{12'h004, 16'h0001, 16'h0002, 5'h00, 1'b0, 16'h0003, 4'b0000, 1'b0};
      tbl[17] = '{12'h010, 16'hFFFF, 16'hFFFF, 5'h00, 1'b0, 16'h0001, 4'b0000, 1'b0};
      tbl[18] = '{12'h010, 16'h8000, 16'h0002, 5'h00, 1'b0, 16'h0000, 4'b0100, 1'b0};
      tbl[19] = '{12'h020, 16'h0003, 16'h0005, 5'h00, 1'b0, 16'h0000, 4'b1000, 1'b0};
      tbl[20] = '{12'h010, 16'h0003, 16'h7777, 5'h1E, 1'b1, 16'hFFFA, 4'b1000, 1'b0};
      tbl[21] = '{12'h400, 16'h0001, 16'h000F, 5'h00, 1'b0, 16'h8000, 4'b1000, 1'b0};
      tbl[22] = '{12'h810, 16'h0003, 16'h0004, 5'h00, 1'b0, 16'h0000, 4'b0000, 1'b1};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; alusignals = 12'h0;
      op1 = 16'h0; op2 = 16'h0; immx = 5'h0; isimmediate = 1'b0; in_tag = 4'h0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_aluresult", 32'(aluresult), 32'd0);
      chk("rst_flags", 32'(flags), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      rst_n = 1'b1;
      #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < 23; i++) run_op(tbl[i], 4'(i + 3), i);

      // Reset in the middle of a MUL must drop it
      @(negedge clk);
      alusignals = 12'h010; op1 = 16'h0007; op2 = 16'h0009; isimmediate = 1'b0;
      in_tag = 4'hA; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("midmul_in_ready", 32'(in_ready), 32'd1);
      chk("midmul_out_valid", 32'(out_valid), 32'd0);
      bad = 0;
      repeat (25) begin
         @(negedge clk);
         if (out_valid) bad++;
      end
      chk("midmul_no_result", 32'(bad), 32'd0);
      run_op('{12'h010, 16'h0007, 16'h0009, 5'h00, 1'b0, 16'h003F, 4'b0000, 1'b0}, 4'h5, 99);

      // Backpressure: first result held, then full-throughput drain
      @(negedge clk);
      out_ready = 1'b0;
      alusignals = 12'h001; op1 = 16'h0001; op2 = 16'h0001; in_tag = 4'h1; in_valid = 1'b1;
      @(negedge clk);
      op1 = 16'h0002; op2 = 16'h0002; in_tag = 4'h2;
      bad = 0;
      repeat (4) begin
         #1 if (!out_valid || aluresult !== 16'h0002 || out_tag !== 4'h1 || in_ready) bad++;
         @(negedge clk);
      end
      chk("bp_hold", 32'(bad), 32'd0);
      out_ready = 1'b1;
      #1 chk("bp_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      chk("bp_second", {out_valid, 11'h0, out_tag, aluresult}, {1'b1, 11'h0, 4'h2, 16'h0004});
      op1 = 16'h0003; op2 = 16'h0003; in_tag = 4'h3;
      @(negedge clk);
      chk("bp_third", {out_valid, 11'h0, out_tag, aluresult}, {1'b1, 11'h0, 4'h3, 16'h0006});
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_drained", 32'(out_valid), 32'd0);

      // Random traffic with independent backpressure against the scoreboard
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         n = $urandom_range(0, 12);
         alusignals  = (n == 12) ? 12'($urandom) : 12'(1 << n);
         op1         = 16'($urandom);
         op2         = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
         immx        = 5'($urandom);
         isimmediate = 1'($urandom);
         in_tag      = 4'($urandom);
         in_valid    = ($urandom_range(0, 3) != 0);
         out_ready   = ($urandom_range(0, 3) != 0);
         #1;
         if (in_valid && in_ready) begin
            e = model(alusignals, op1, op2, immx, isimmediate);
            e.tag = in_tag;
            sb.push_back(e);
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("rand_unexpected", 32'(out_valid), 32'd0);
            end else begin
               e   = sb.pop_front();
               got = '{res: aluresult, fl: flags, er: err, tag: out_tag};
               chk("rand_result", {11'h0, got.er, got.tag, got.fl, got.res},
                   {11'h0, e.er, e.tag, e.fl, e.res});
            end
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 60 && (sb.size() != 0 || out_valid); k++) begin
         @(negedge clk);
         #1;
         if (out_valid && sb.size() != 0) begin
            e = sb.pop_front();
            chk("drain_result", {11'h0, err, out_tag, flags, aluresult},
                {11'h0, e.er, e.tag, e.fl, e.res});
         end
      end
      chk("drain_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
